// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HSIZE_BYTE = 2'b00,
        HSIZE_HALF = 2'b01,
        HSIZE_WORD = 2'b10
    } hsize_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_ERR    = 2'b10,
        ST_CANCEL = 2'b11
    } state_e;

endpackage

// File: rtl/ahb_wait_timer.sv
// Counts consecutive stalled data-phase cycles and flags the abort cycle.
module ahb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_data,
    input  logic hready,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Fires on the edge that would complete the final allowed wait cycle
    assign expired = in_data && !hready && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!in_data || hready)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite master with pipelined address/data phases.
// Optional wait-state abort enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        hsel,
    output logic [3:0]  haddr,
    output logic [1:0]  htrans,
    output logic [1:0]  hsize,
    output logic        hwrite,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hresp,
    input  logic        hready
);

    state_e      state, state_nxt;
    logic        addr_pend, accept, addr_done, data_end;
    logic        err_first, tmo, pend_any;
    logic        cancel_pend, data_write;
    logic [31:0] addr_wdata;

    assign addr_pend = (htrans == HTRANS_NONSEQ);
    assign accept    = cmd_valid && cmd_ready;
    assign addr_done = addr_pend && hready;
    assign data_end  = (state == ST_DATA) && hready;
    assign err_first = (state == ST_DATA) && hresp && !hready;
    assign pend_any  = addr_pend || accept;

`ifdef AHB_MASTER_TIMEOUT_EN
    logic tmo_raw;
    logic rsp_tmo_q;

    ahb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .in_data (state == ST_DATA),
        .hready  (hready),
        .expired (tmo_raw)
    );

    // An error response on the same cycle takes precedence over the abort
    assign tmo = tmo_raw && !hresp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rsp_tmo_q <= 1'b0;
        else
            rsp_tmo_q <= tmo;
    end

    assign rsp_timeout = rsp_tmo_q;
`else
    assign tmo         = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (addr_done)
                    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (err_first)
                    state_nxt = ST_ERR;
                else if (tmo)
                    state_nxt = pend_any ? ST_CANCEL : ST_IDLE;
                else if (hready)
                    state_nxt = addr_done ? ST_DATA : ST_IDLE;
            end
            ST_ERR: begin
                if (hready)
                    state_nxt = cancel_pend ? ST_CANCEL : ST_IDLE;
            end
            ST_CANCEL: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        unique case (state)
            ST_IDLE, ST_DATA: cmd_ready = !addr_pend || hready;
            default:          cmd_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            htrans      <= HTRANS_IDLE;
            hsel        <= 1'b0;
            haddr       <= '0;
            hsize       <= '0;
            hwrite      <= 1'b0;
            hwdata      <= '0;
            addr_wdata  <= '0;
            data_write  <= 1'b0;
            cancel_pend <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;

            if (accept) begin
                htrans     <= HTRANS_NONSEQ;
                hsel       <= 1'b1;
                haddr      <= cmd_addr;
                hsize      <= cmd_size;
                hwrite     <= cmd_write;
                addr_wdata <= cmd_wdata;
            end else if (addr_done) begin
                htrans <= HTRANS_IDLE;
                hsel   <= 1'b0;
            end

            if (addr_done) begin
                hwdata     <= addr_wdata;
                data_write <= hwrite;
            end

            // Abort: drop any address phase, including one accepted this edge
            if (err_first || tmo) begin
                htrans      <= HTRANS_IDLE;
                hsel        <= 1'b0;
                cancel_pend <= pend_any;
            end

            if (data_end) begin
                rsp_valid <= 1'b1;
                rsp_error <= hresp;
                rsp_rdata <= (data_write || hresp) ? '0 : hrdata;
            end else if ((state == ST_ERR && hready) ||
                         state == ST_CANCEL || tmo) begin
                rsp_valid <= 1'b1;
                rsp_error <= 1'b1;
            end
        end
    end

endmodule
